// File: rtl/mdu_hilo_if.sv
// Operand/opcode bus between the EX stage and the HI/LO multiply-divide unit.
// The EX stage drives operands and the opcode; the unit returns HI/LO, Busy and Pending.
interface mdu_hilo_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDop;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Pending;

    modport master (
        output A, B, MDop, Start,
        input  Busy, HI, LO, Pending
    );

    modport slave (
        input  A, B, MDop, Start,
        output Busy, HI, LO, Pending
    );
endinterface

// File: rtl/mdu_hilo.sv
// Multi-cycle MULT/DIV unit owning the architectural HI/LO registers.
// The result is computed at issue and parked in holding registers until the busy count expires.
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_hilo_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_RSVD  = 3'b111
    } mdop_e;

    mdop_e             op;
    logic              accept;
    logic              is_md;
    logic [31:0]       res_hi;
    logic [31:0]       res_lo;
    logic              res_wr;
    logic [CNT_W-1:0]  res_cnt;

    logic              busy_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [31:0]       hi_reg;
    logic [31:0]       lo_reg;
    logic [31:0]       hold_hi;
    logic [31:0]       hold_lo;
    logic              hold_wr;

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [63:0] div_s;

    // Signed divide on magnitudes, so -2^31 / -1 wraps to 0x80000000 with remainder 0.
    // Returns {remainder, quotient}; a zero divisor is replaced by 1 since that result is discarded.
    function automatic logic [63:0] div_signed(input logic signed [31:0] n,
                                               input logic signed [31:0] d);
        logic [31:0] n_mag;
        logic [31:0] d_mag;
        logic [31:0] q_mag;
        logic [31:0] r_mag;
        logic [31:0] quo;
        logic [31:0] rem;
        n_mag = n[31] ? 32'(-n) : 32'(n);
        d_mag = d[31] ? 32'(-d) : 32'(d);
        if (d_mag == 32'd0) begin
            d_mag = 32'd1;
        end
        q_mag = n_mag / d_mag;
        r_mag = n_mag % d_mag;
        quo   = (n[31] ^ d[31]) ? -q_mag : q_mag;
        rem   = n[31] ? -r_mag : r_mag;
        return {rem, quo};
    endfunction

    assign op     = mdop_e'(bus.MDop);
    assign accept = bus.Start && !busy_reg;

    assign a_sx   = {{32{bus.A[31]}}, bus.A};
    assign b_sx   = {{32{bus.B[31]}}, bus.B};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    assign div_s  = div_signed(bus.A, bus.B);

    // Issue-side decode: what would be parked if this opcode were accepted now.
    always_comb begin
        is_md   = 1'b0;
        res_hi  = 32'd0;
        res_lo  = 32'd0;
        res_wr  = 1'b0;
        res_cnt = '0;
        case (op)
            OP_MULT: begin
                is_md   = 1'b1;
                res_hi  = prod_s[63:32];
                res_lo  = prod_s[31:0];
                res_wr  = 1'b1;
                res_cnt = CNT_W'(MULT_CYCLES);
            end
            OP_MULTU: begin
                is_md   = 1'b1;
                res_hi  = prod_u[63:32];
                res_lo  = prod_u[31:0];
                res_wr  = 1'b1;
                res_cnt = CNT_W'(MULT_CYCLES);
            end
            OP_DIV: begin
                is_md   = 1'b1;
                res_hi  = div_s[63:32];
                res_lo  = div_s[31:0];
                res_wr  = (bus.B != 32'd0);
                res_cnt = CNT_W'(DIV_CYCLES);
            end
            OP_DIVU: begin
                is_md   = 1'b1;
                res_hi  = (bus.B != 32'd0) ? (bus.A % bus.B) : 32'd0;
                res_lo  = (bus.B != 32'd0) ? (bus.A / bus.B) : 32'd0;
                res_wr  = (bus.B != 32'd0);
                res_cnt = CNT_W'(DIV_CYCLES);
            end
            default: begin
                is_md   = 1'b0;
            end
        endcase
    end

    // A busy unit ignores Start entirely; HI/LO only move at completion or on MTHI/MTLO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_reg <= 1'b0;
            cnt_reg  <= '0;
            hi_reg   <= 32'd0;
            lo_reg   <= 32'd0;
            hold_hi  <= 32'd0;
            hold_lo  <= 32'd0;
            hold_wr  <= 1'b0;
        end else if (busy_reg) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
                busy_reg <= 1'b0;
                if (hold_wr) begin
                    hi_reg <= hold_hi;
                    lo_reg <= hold_lo;
                end
            end
        end else if (accept) begin
            if (is_md) begin
                busy_reg <= 1'b1;
                cnt_reg  <= res_cnt;
                hold_hi  <= res_hi;
                hold_lo  <= res_lo;
                hold_wr  <= res_wr;
            end else if (op == OP_MTHI) begin
                hi_reg <= bus.A;
            end else if (op == OP_MTLO) begin
                lo_reg <= bus.A;
            end
        end
    end

    assign bus.Busy    = busy_reg;
    assign bus.HI      = hi_reg;
    assign bus.LO      = lo_reg;
    assign bus.Pending = busy_reg | (bus.Start & is_md);

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: directed vector table, hand-written MT/reset sequences,
// and randomized operations checked against a plain-arithmetic HI/LO model.
module tb_mdu_hilo;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [2:0] NONE  = 3'd0;
    localparam logic [2:0] MULT  = 3'd1;
    localparam logic [2:0] MULTU = 3'd2;
    localparam logic [2:0] DIV   = 3'd3;
    localparam logic [2:0] DIVU  = 3'd4;
    localparam logic [2:0] MTHI  = 3'd5;
    localparam logic [2:0] MTLO  = 3'd6;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_hilo_if bus();

    mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cycles;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected architectural effect of one issued instruction, from the ISA definition.
    function automatic void model(input logic st, input logic [2:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  inout logic [31:0] hi, inout logic [31:0] lo,
                                  output int n);
        longint sa;
        longint sb;
        longint sp;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        n  = 0;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        if (!st) return;
        case (op)
            MULT:  begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; n = MC; end
            MULTU: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; n = MC; end
            DIV: begin
                if (b != 0) begin sp = sa / sb; lo = sp[31:0]; sp = sa % sb; hi = sp[31:0]; end
                n = DC;
            end
            DIVU: begin
                if (b != 0) begin up = ua / ub; lo = up[31:0]; up = ua % ub; hi = up[31:0]; end
                n = DC;
            end
            MTHI: hi = a;
            MTLO: lo = a;
            default: n = 0;
        endcase
    endfunction

    // Called #1 after a rising edge. inj: 0 idle while busy, 1 MULT at busy cycle 2, 2 random traffic.
    task automatic do_op(input logic st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input int en, input int inj);
        logic [31:0] ph;
        logic [31:0] pl;
        int cnt;
        ph = bus.HI;
        pl = bus.LO;
        bus.A = a;
        bus.B = b;
        bus.MDop = op;
        bus.Start = st;
        #1;
        chk("pending_issue", {63'd0, bus.Pending}, {63'd0, st && op >= MULT && op <= DIVU});
        @(posedge clk); #1;
        bus.Start = 1'b0;
        bus.MDop = NONE;
        bus.A = $urandom;
        bus.B = $urandom;
        cnt = 0;
        while (bus.Busy && cnt < 100) begin
            chk("pending_busy", {63'd0, bus.Pending}, 64'd1);
            chk("hi_hold", {32'd0, bus.HI}, {32'd0, ph});
            chk("lo_hold", {32'd0, bus.LO}, {32'd0, pl});
            if (inj == 1 && cnt == 1) begin
                bus.Start = 1'b1; bus.MDop = MULT; bus.A = 32'h55; bus.B = 32'h77;
            end else if (inj == 2) begin
                bus.Start = 1'($urandom); bus.MDop = 3'($urandom); bus.A = $urandom; bus.B = $urandom;
            end else begin
                bus.Start = 1'b0; bus.MDop = NONE;
            end
            @(posedge clk); #1;
            cnt++;
        end
        bus.Start = 1'b0;
        bus.MDop = NONE;
        chk("busy_cycles", 64'(cnt), 64'(en));
        chk("hi_result", {32'd0, bus.HI}, {32'd0, eh});
        chk("lo_result", {32'd0, bus.LO}, {32'd0, el});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        st;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        int          busy_seen;

        tests = 0;
        fails = 0;
        vecs[0] = '{32'h0,        32'h0,        MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MC};
        vecs[1] = '{32'h0,        32'h0,        MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC};
        vecs[2] = '{32'h0,        32'h0,        DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DC};
        vecs[3] = '{32'h11111111, 32'h22222222, DIVU,  32'd100,      32'd0,        32'h11111111, 32'h22222222, DC};
        vecs[4] = '{32'h1,        32'h1,        DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DC};
        vecs[5] = '{32'h0,        32'h0,        DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       DC};
        vecs[6] = '{32'h0,        32'h0,        DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DC};
        vecs[7] = '{32'hAAAAAAAA, 32'h55555555, DIV,   32'hFFFFFF00, 32'd0,        32'hAAAAAAAA, 32'h55555555, DC};
        vecs[8] = '{32'h0,        32'h0,        MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, MC};
        vecs[9] = '{32'h0,        32'h0,        MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MC};

        reset = 1'b1;
        bus.A = 32'd0;
        bus.B = 32'd0;
        bus.MDop = NONE;
        bus.Start = 1'b0;
        #1;
        chk("reset_busy", {63'd0, bus.Busy}, 64'd0);
        chk("reset_hi", {32'd0, bus.HI}, 64'd0);
        chk("reset_lo", {32'd0, bus.LO}, 64'd0);
        chk("reset_pending", {63'd0, bus.Pending}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;

        for (int i = 0; i < 10; i++) begin
            do_op(1'b1, MTHI, vecs[i].pre_hi, 32'd0, vecs[i].pre_hi, m_lo, 0, 0);
            do_op(1'b1, MTLO, vecs[i].pre_lo, 32'd0, vecs[i].pre_hi, vecs[i].pre_lo, 0, 0);
            do_op(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo,
                  vecs[i].cycles, 0);
            m_hi = vecs[i].exp_hi;
            m_lo = vecs[i].exp_lo;
        end

        // MTLO then MTHI on consecutive edges, then a MULT with an ignored re-issue mid-flight.
        do_op(1'b1, MTLO, 32'h12345678, 32'd0, m_hi, 32'h12345678, 0, 0);
        do_op(1'b1, MTHI, 32'hCAFEBABE, 32'd0, 32'hCAFEBABE, 32'h12345678, 0, 0);
        do_op(1'b1, MULT, 32'd3, 32'd4, 32'd0, 32'd12, MC, 1);
        m_hi = 32'd0;
        m_lo = 32'd12;

        // Opcodes that must change nothing.
        do_op(1'b1, NONE, 32'hDEAD, 32'h1, m_hi, m_lo, 0, 0);
        do_op(1'b1, 3'd7, 32'hDEAD, 32'h1, m_hi, m_lo, 0, 0);
        do_op(1'b0, MULT, 32'hDEAD, 32'h1, m_hi, m_lo, 0, 0);
        do_op(1'b0, MTHI, 32'hDEAD, 32'h1, m_hi, m_lo, 0, 0);

        for (int i = 0; i < 40; i++) begin
            st = ($urandom_range(0, 7) != 0);
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            model(st, op, a, b, m_hi, m_lo, n);
            do_op(st, op, a, b, m_hi, m_lo, n, 2);
        end

        // Reset at busy cycle 3 of a DIV aborts it with no late update.
        do_op(1'b1, MTHI, 32'h0BADF00D, 32'd0, 32'h0BADF00D, m_lo, 0, 0);
        bus.Start = 1'b1; bus.MDop = DIV; bus.A = 32'd100; bus.B = 32'd3;
        @(posedge clk); #1;
        bus.Start = 1'b0; bus.MDop = NONE;
        chk("div_started", {63'd0, bus.Busy}, 64'd1);
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        chk("abort_busy", {63'd0, bus.Busy}, 64'd0);
        chk("abort_hi", {32'd0, bus.HI}, 64'd0);
        chk("abort_lo", {32'd0, bus.LO}, 64'd0);
        chk("abort_pending", {63'd0, bus.Pending}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        busy_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.Busy) busy_seen++;
        end
        chk("no_late_busy", 64'(busy_seen), 64'd0);
        chk("no_late_hi", {32'd0, bus.HI}, 64'd0);
        chk("no_late_lo", {32'd0, bus.LO}, 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;

        // First Start after reset is accepted normally.
        do_op(1'b1, MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, MC, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
MDU_HILO -- requirements
Module: mdu_hilo

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- MULT_CYCLES, 5: cycles Busy stays high for MULT/MULTU.
- DIV_CYCLES, 10: cycles Busy stays high for DIV/DIVU.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high; clears all state.
- A, input, 32: rs operand (already forwarded).
- B, input, 32: rt operand (already forwarded).
- MDop, input, 3: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 111 is treated as none.
- Start, input, 1: EX-stage instruction is valid and not flushed; qualifies MDop.
- Busy, output, 1: an operation is in flight.
- HI, output, 32: architectural HI register, registered.
- LO, output, 32: architectural LO register, registered.
- Pending, output, 1: Busy OR (Start AND MDop in 001..100); drives the hazard unit's MFHI/MFLO/MT*/MD stall.

Function
REQ-003 The block SHALL sample Start and MDop only on a rising clk edge while Busy=0.
- Start=1 with MDop 001..100 SHALL:
  - latch the result into internal holding registers;
  - set Busy=1 from the next cycle;
  - load the counter with MULT_CYCLES or DIV_CYCLES.
REQ-004 While Busy=1, the counter SHALL decrement on each edge.
- On the edge where the counter goes from 1 to 0, HI/LO SHALL take the held result and Busy SHALL fall on that same edge.
- Busy is therefore high for exactly N cycles.
REQ-005 MULT: {HI,LO} SHALL equal signed(A)*signed(B) as a 64-bit product.
- MULTU: {HI,LO} SHALL equal the unsigned 64-bit product.
REQ-006 DIV: LO SHALL be the quotient truncated toward zero, and HI SHALL be the remainder with the dividend's sign.
- 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-007 DIVU SHALL give LO=A/B and HI=A%B, both unsigned.
REQ-008 A divide with B=0 SHALL still run DIV_CYCLES with Busy high, but SHALL leave HI and LO unchanged at completion.
REQ-009 MTHI/MTLO with Start=1 and Busy=0 SHALL write A into HI or LO on that edge, with no Busy cycle and the other register unchanged.
REQ-010 Start=1 while Busy=1 SHALL be ignored for every MDop.
- The hazard unit guarantees this via Pending; the block does not queue.
REQ-011 Start=0, MDop=none and MDop=111 SHALL change nothing.
REQ-012 HI and LO SHALL be readable every cycle.
- During Busy they SHALL hold their pre-operation values.
- The downstream forwarding path captures them into the MEM/WB pipeline registers as HI_MEM/LO_MEM and HI_WB/LO_WB.
REQ-013 Pending SHALL be purely combinational from Busy, Start and MDop.
- All other outputs SHALL be register outputs.
REQ-014 The result arithmetic SHALL be computed at issue from the A and B values sampled on the Start edge.
- Later changes on A and B SHALL have no effect.

Reset
REQ-015 Asserting reset SHALL asynchronously set HI=0, LO=0, Busy=0, counter=0 and the holding registers to 0.
REQ-016 Reset asserted mid-operation SHALL abort it: no HI/LO update occurs, and Busy=0 from the reset assertion onward.
REQ-017 After reset deasserts, the first rising edge with Start=1 SHALL be accepted normally.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- MULT, A=0xFFFFFFFE (-2), B=3 -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU, A=100, B=0 -> Busy high 10 cycles, then HI/LO keep their prior values (e.g. 0x11111111 and 0x22222222).
- MTLO with A=0x12345678, then MTHI with A=0xCAFEBABE on consecutive edges -> LO=0x12345678 and HI=0xCAFEBABE; Busy never rises; a MULT issued at cycle 2 of Busy is ignored; Pending is high through the whole Busy window.
- Reset asserted at cycle 3 of a DIV -> Busy=0 and HI=LO=0 immediately; no late update occurs.
